// File: rtl/pipelined_adder.sv
`default_nettype none
// pipelined_adder -- WIDTH-bit add/sub split into STAGES carry-chained slices, valid/ready with backpressure.
// Rev 1.0
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic [1:0]       io_op,
  input  logic             io_cin,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_c,
  output logic             io_cout,
  output logic             io_ovf
);

  localparam int SLICE = WIDTH / STAGES;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADC  = 2'b10;
  localparam logic [1:0] OP_RSUB = 2'b11;

  logic             vld_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic             ovf_q   [STAGES];

  logic             stall;
  logic [WIDTH-1:0] a_map;
  logic [WIDTH-1:0] b_map;
  logic             cin_map;

  // Subtractions become additions of an inverted operand plus one.
  always_comb begin
    a_map   = io_a;
    b_map   = io_b;
    cin_map = 1'b0;
    case (io_op)
      OP_ADD:  cin_map = 1'b0;
      OP_SUB: begin
        b_map   = ~io_b;
        cin_map = 1'b1;
      end
      OP_ADC:  cin_map = io_cin;
      OP_RSUB: begin
        a_map   = io_b;
        b_map   = ~io_a;
        cin_map = 1'b1;
      end
      default: cin_map = 1'b0;
    endcase
  end

  assign stall       = vld_q[STAGES-1] && !io_out_ready;
  assign io_in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic             c_in;
    logic [SLICE:0]   slice_add;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    if (k == 0) begin : g_first
      assign vld_in = io_in_valid && io_in_ready;
      assign a_in   = a_map;
      assign b_in   = b_map;
      assign sum_in = '0;
      assign c_in   = cin_map;
    end else begin : g_next
      assign vld_in = vld_q[k-1];
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign sum_in = sum_q[k-1];
      assign c_in   = carry_q[k-1];
    end

    // Only meaningful in the last stage, where this slice holds the MSB.
    always_comb begin
      slice_add = {1'b0, a_in[k*SLICE +: SLICE]} + {1'b0, b_in[k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, c_in};
      sum_next  = sum_in;
      sum_next[k*SLICE +: SLICE] = slice_add[SLICE-1:0];
      ovf_next  = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ slice_add[SLICE-1] ^ slice_add[SLICE];
    end

    // Data loads only with a valid item so idle outputs keep the last result.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[k]   <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        ovf_q[k]   <= 1'b0;
      end else if (!stall) begin
        vld_q[k] <= vld_in;
        if (vld_in) begin
          a_q[k]     <= a_in;
          b_q[k]     <= b_in;
          sum_q[k]   <= sum_next;
          carry_q[k] <= slice_add[SLICE];
          ovf_q[k]   <= ovf_next;
        end
      end
    end
  end

  assign io_out_valid = vld_q[STAGES-1];
  assign io_c         = sum_q[STAGES-1];
  assign io_cout      = carry_q[STAGES-1];
  assign io_ovf       = ovf_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// tb_pipelined_adder -- scoreboard bench for 16/2, 32/4 and 8/1 configurations.
// Rev 1.0
module tb_pipelined_adder;

  typedef struct {
    logic [31:0] c;
    logic        cout;
    logic        ovf;
    int          acc;
    int          st;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic in_valid0, in_ready0, cin0, out_valid0, out_ready0, cout0, ovf0;
  logic [15:0] a0, b0, c0;
  logic [1:0]  op0;
  logic in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1;
  logic [31:0] a1, b1, c1;
  logic [1:0]  op1;
  logic in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, ovf2;
  logic [7:0]  a2, b2, c2;
  logic [1:0]  op2;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   st0 = 0, st1 = 0, st2 = 0;
  logic held0, held1, held2;
  logic [31:0] pc0, pc1, pc2;
  logic [1:0]  pf0, pf1, pf2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(16), .STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .io_in_valid(in_valid0), .io_in_ready(in_ready0),
    .io_a(a0), .io_b(b0), .io_op(op0), .io_cin(cin0), .io_out_valid(out_valid0),
    .io_out_ready(out_ready0), .io_c(c0), .io_cout(cout0), .io_ovf(ovf0));

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut1 (
    .clk(clk), .reset(reset), .io_in_valid(in_valid1), .io_in_ready(in_ready1),
    .io_a(a1), .io_b(b1), .io_op(op1), .io_cin(cin1), .io_out_valid(out_valid1),
    .io_out_ready(out_ready1), .io_c(c1), .io_cout(cout1), .io_ovf(ovf1));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut2 (
    .clk(clk), .reset(reset), .io_in_valid(in_valid2), .io_in_ready(in_ready2),
    .io_a(a2), .io_b(b2), .io_op(op2), .io_cin(cin2), .io_out_valid(out_valid2),
    .io_out_ready(out_ready2), .io_c(c2), .io_cout(cout2), .io_ovf(ovf2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: widen, add, then derive flags from operand and result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic cin, input int acc, input int st);
    logic [63:0] mask, am, bm, full;
    logic        ci;
    exp_t        r;
    mask = (64'd1 << w) - 64'd1;
    am = {32'd0, a} & mask;
    bm = {32'd0, b} & mask;
    ci = 1'b0;
    case (op)
      2'b01: begin bm = ~bm & mask; ci = 1'b1; end
      2'b10: ci = cin;
      2'b11: begin bm = ~am & mask; am = {32'd0, b} & mask; ci = 1'b1; end
      default: ci = 1'b0;
    endcase
    full   = am + bm + {63'd0, ci};
    r.c    = 32'(full & mask);
    r.cout = full[w];
    r.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    r.acc  = acc;
    r.st   = st;
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q0.delete(); held0 = 1'b0;
    end else begin
      check("in_ready0", in_ready0, !(out_valid0 && !out_ready0));
      if (held0) begin
        check("hold_c0", c0, pc0);
        check("hold_flags0", {cout0, ovf0}, pf0);
      end
      held0 = out_valid0 && !out_ready0;
      pc0 = 32'(c0); pf0 = {cout0, ovf0};
      if (out_valid0 && out_ready0) begin
        check("out_expected0", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e0 = q0.pop_front();
          check("c0", c0, e0.c);
          check("cout0", cout0, e0.cout);
          check("ovf0", ovf0, e0.ovf);
          check("lat0", cyc, e0.acc + 2 + (st0 - e0.st));
        end
      end
      if (held0) st0++;
      if (in_valid0 && in_ready0) q0.push_back(model(16, 32'(a0), 32'(b0), op0, cin0, cyc, st0));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q1.delete(); held1 = 1'b0;
    end else begin
      check("in_ready1", in_ready1, !(out_valid1 && !out_ready1));
      if (held1) check("hold1", {c1, cout1, ovf1}, {pc1, pf1});
      held1 = out_valid1 && !out_ready1;
      pc1 = c1; pf1 = {cout1, ovf1};
      if (out_valid1 && out_ready1) begin
        check("out_expected1", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          check("res1", {c1, cout1, ovf1}, {e1.c, e1.cout, e1.ovf});
          check("lat1", cyc, e1.acc + 4 + (st1 - e1.st));
        end
      end
      if (held1) st1++;
      if (in_valid1 && in_ready1) q1.push_back(model(32, a1, b1, op1, cin1, cyc, st1));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q2.delete(); held2 = 1'b0;
    end else begin
      check("in_ready2", in_ready2, !(out_valid2 && !out_ready2));
      if (held2) check("hold2", {c2, cout2, ovf2}, {pc2[7:0], pf2});
      held2 = out_valid2 && !out_ready2;
      pc2 = 32'(c2); pf2 = {cout2, ovf2};
      if (out_valid2 && out_ready2) begin
        check("out_expected2", q2.size() > 0, 1);
        if (q2.size() > 0) begin
          e2 = q2.pop_front();
          check("res2", {c2, cout2, ovf2}, {e2.c[7:0], e2.cout, e2.ovf});
          check("lat2", cyc, e2.acc + 1 + (st2 - e2.st));
        end
      end
      if (held2) st2++;
      if (in_valid2 && in_ready2) q2.push_back(model(8, 32'(a2), 32'(b2), op2, cin2, cyc, st2));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input logic cin);
    int n;
    a0 = a; b0 = b; op0 = op; cin0 = cin; in_valid0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready0 && n < 200);
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q0.size() + q1.size() + q2.size()) > 0; i++) @(negedge clk);
  endtask

  task automatic sweep_drive1();
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      in_valid1  = $urandom_range(0, 3) != 0;
      out_ready1 = $urandom_range(0, 4) != 0;
      a1 = $urandom(); b1 = $urandom(); op1 = 2'($urandom()); cin1 = 1'($urandom());
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0; out_ready1 = 1'b1;
  endtask

  task automatic sweep_drive2();
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      in_valid2  = $urandom_range(0, 3) != 0;
      out_ready2 = $urandom_range(0, 4) != 0;
      a2 = 8'($urandom()); b2 = 8'($urandom()); op2 = 2'($urandom()); cin2 = 1'($urandom());
    end
    @(posedge clk);
    #1 in_valid2 = 1'b0; out_ready2 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int st_before;
    reset = 1'b1;
    in_valid0 = 0; a0 = 0; b0 = 0; op0 = 0; cin0 = 0; out_ready0 = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; op1 = 0; cin1 = 0; out_ready1 = 1;
    in_valid2 = 0; a2 = 0; b2 = 0; op2 = 0; cin2 = 0; out_ready2 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid0, 0);
    check("rst_c", c0, 0);
    check("rst_cout", cout0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_out_valid1", out_valid1, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready0, 1);

    send(16'd3, 16'd7, 2'b00, 1'b0);
    send(16'd21, 16'd8, 2'b00, 1'b0);
    send(16'd4, 16'd7, 2'b00, 1'b0);
    send(16'h00FF, 16'h0001, 2'b00, 1'b0);
    send(16'hFFFF, 16'h0001, 2'b00, 1'b0);
    send(16'h7FFF, 16'h0001, 2'b00, 1'b0);
    send(16'd4, 16'd7, 2'b01, 1'b0);
    send(16'd4, 16'd7, 2'b11, 1'b0);
    send(16'h8000, 16'h0001, 2'b01, 1'b0);
    send(16'hFFFE, 16'h0001, 2'b10, 1'b1);
    send(16'hFFFE, 16'h0001, 2'b00, 1'b1);
    drain();

    // Backpressure: consumer stalls for five cycles in the middle of a stream.
    st_before = st0;
    fork
      for (int i = 0; i < 6; i++) send(16'($urandom()), 16'($urandom()), 2'($urandom()), 1'($urandom()));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready0 = 1'b1;
      end
    join
    drain();
    check("stall_seen", st0 - st_before, 5);

    // Reset lands on the edge where the first item would become visible.
    send(16'd100, 16'd200, 2'b00, 1'b0);
    a0 = 16'd5; b0 = 16'd6; in_valid0 = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; in_valid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", out_valid0, 0);
      check("post_rst_c", c0, 0);
    end
    send(16'h1234, 16'h1111, 2'b00, 1'b0);
    drain();

    fork
      sweep_drive1();
      sweep_drive2();
    join
    drain();

    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the team's single-register 16-bit adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained slices, one slice per pipeline stage.
- Adds a valid/ready handshake with full backpressure, an operation select, carry-out and signed-overflow flags.
- Sits between producer/consumer datapath blocks that need one result per clock at arbitrary widths.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, pipeline depth and number of carry slices; each slice is SLICE = WIDTH/STAGES bits; legal values 1..WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  operands/op present this cycle.
- io_in_ready  output  1  block accepts operands this cycle.
- io_a  input  WIDTH  operand A.
- io_b  input  WIDTH  operand B.
- io_op  input  2  00 add A+B; 01 sub A-B; 10 add-with-carry A+B+io_cin; 11 reverse sub B-A.
- io_cin  input  1  carry-in; used only for op 10.
- io_out_valid  output  1  result present.
- io_out_ready  input  1  consumer takes result this cycle.
- io_c  output  WIDTH  result, modulo 2^WIDTH.
- io_cout  output  1  raw carry out of the MSB (for subtract: 1 = no borrow).
- io_ovf  output  1  two's-complement signed overflow of the performed operation.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: all stage valid bits cleared; io_out_valid=0, io_c=0, io_cout=0, io_ovf=0; io_in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards every in-flight item; nothing is emitted afterwards.
- Operand mapping:
  - Sub: A + ~B + 1.
  - Reverse sub: B + ~A + 1.
  - Add: carry-in 0.
  - Add-with-carry: carry-in io_cin.
  - Mapping happens at accept.
- Slicing: stage k (0-based) adds slice k of both mapped operands plus the carry registered from stage k-1 (stage 0 uses the mapped carry-in). Upper slices not yet added travel alongside in pipeline registers; lower result slices already computed travel forward.
- Overflow: computed in the final stage as (carry into MSB) XOR (carry out of MSB).
- Transfers:
  - Input transfer occurs when io_in_valid && io_in_ready.
  - Output transfer occurs when io_out_valid && io_out_ready.
- Stall: stall = io_out_valid && !io_out_ready. io_in_ready = !stall (combinational from io_out_ready). During stall every stage register holds; io_c/io_cout/io_ovf stay stable.
- Bubbles: when not stalled all stages advance every cycle; bubbles (valid=0) propagate and do not block.
- Latency and throughput: an item accepted at edge N appears with io_out_valid=1 after edge N+STAGES-1 and is visible in the following cycle. Latency is exactly STAGES cycles with no stall. Throughput is one result per clock.
- STAGES=1: degenerates to a single registered adder, latency 1.
- Ordering: results leave in acceptance order; no drop, no duplication.
- Idle outputs: when io_out_valid=0, io_c/io_cout/io_ovf hold their last value (not required zero except after reset).
- Concurrency: simultaneous accept and output transfer in the same cycle is legal and required for full throughput.

Test Plan:
- WIDTH=16, STAGES=2, out_ready=1: add 3+7, then 21+8, then 4+7 on consecutive cycles -> io_c=10, 29, 11 on three consecutive cycles, first one 2 cycles after accept; cout=0, ovf=0.
- Carry across slice boundary: add 0x00FF+0x0001 -> 0x0100. Add 0xFFFF+0x0001 -> io_c=0x0000, cout=1, ovf=0. Add 0x7FFF+0x0001 -> io_c=0x8000, cout=0, ovf=1.
- Subtract and mode coverage:
  - op 01, 4-7 -> 0xFFFD, cout=0, ovf=0.
  - op 11 with a=4, b=7 -> 0x0003, cout=1.
  - op 01, 0x8000-0x0001 -> 0x7FFF, ovf=1.
  - op 10, 0xFFFE+0x0001+cin=1 -> 0x0000, cout=1.
- Backpressure: stream 6 operand pairs continuously while io_out_ready is low for 5 cycles mid-stream -> in_ready drops during stall, output held stable, all 6 results delivered in order with correct values.
- Reset mid-operation: accept 2 items, assert reset 1 cycle before the first would emerge -> io_out_valid stays 0, io_c=0; a new item after reset returns after exactly STAGES cycles.
- Parameter sweep: WIDTH=32 STAGES=4 and WIDTH=8 STAGES=1, random operands/ops vs reference model -> zero mismatches, latency = STAGES.
